// File: rtl/mem_bus_master_if.sv
// CPU-side request/response interface of the data-memory bus master.
// The master modport belongs to the CPU datapath/control unit.
// The slave modport belongs to mem_bus_master.
// Optional feature macro: MEM_BURST_READ_EN adds req_len (beats-1) and rsp_last.
interface mem_bus_master_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  busy;
`ifdef MEM_BURST_READ_EN
    logic [2:0]            req_len;
    logic                  rsp_last;
`endif

`ifdef MEM_BURST_READ_EN
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_len,
        input  req_ready, rsp_valid, rsp_rdata, busy, rsp_last
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_len,
        output req_ready, rsp_valid, rsp_rdata, busy, rsp_last
    );
`else
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );
`endif

endinterface

// File: rtl/mem_bus_master.sv
// mem_bus_master: initiator for the single-port 32x8 data memory.
// Takes one CPU load/store at a time over valid/ready, drives the memory's
// registered write enable and address plus the shared bidirectional data
// bus, sequences the memory's one-edge read latency (plus READ_WAIT extra
// idle cycles, 0..3) and returns a one-cycle response pulse.
// Optional feature macro: MEM_BURST_READ_EN (multi-beat loads via req_len).
module mem_bus_master #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int READ_WAIT  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_bus_master_if.slave       bus,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_address,
    inout  wire  [DATA_WIDTH-1:0] mem_data
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RADDR,
        RWAIT,
        RCAP
    } state_t;

    localparam bit              HAS_WAIT  = (READ_WAIT > 0);
    localparam logic [1:0]      WAIT_LOAD = HAS_WAIT ? 2'(READ_WAIT - 1) : 2'd0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic                  mem_write_en_q, mem_write_en_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            wait_cnt_q, wait_cnt_d;
    logic                  req_ready;
    logic                  accept;
    logic                  more_beats;
`ifdef MEM_BURST_READ_EN
    logic [2:0]            beats_left_q, beats_left_d;
    logic                  rsp_last_q, rsp_last_d;
`endif

    // Ready only while idle and never while reset is asserted.
    assign req_ready = (state_q == IDLE) && !rst;
    assign accept    = bus.req_valid && req_ready;

`ifdef MEM_BURST_READ_EN
    assign more_beats = (beats_left_q != 3'd0);
`else
    assign more_beats = 1'b0;
`endif

    // Register all state; reset aborts any transfer and drops the write
    // enable immediately so a half-finished store never reaches memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            mem_write_en_q <= 1'b0;
            mem_address_q  <= '0;
            wdata_q        <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            wait_cnt_q     <= 2'd0;
`ifdef MEM_BURST_READ_EN
            beats_left_q   <= 3'd0;
            rsp_last_q     <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            mem_write_en_q <= mem_write_en_d;
            mem_address_q  <= mem_address_d;
            wdata_q        <= wdata_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            wait_cnt_q     <= wait_cnt_d;
`ifdef MEM_BURST_READ_EN
            beats_left_q   <= beats_left_d;
            rsp_last_q     <= rsp_last_d;
`endif
        end
    end

    // Next-state logic: store is one bus cycle, load is address cycle,
    // optional wait cycles, then capture; bursts loop back to RADDR.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = bus.req_we ? WRITE : RADDR;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            RADDR: begin
                state_d = HAS_WAIT ? RWAIT : RCAP;
            end
            RWAIT: begin
                if (wait_cnt_q == 2'd0) begin
                    state_d = RCAP;
                end
            end
            RCAP: begin
                state_d = more_beats ? RADDR : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and registered-output next values for each state.
    always_comb begin
        mem_write_en_d = 1'b0;
        mem_address_d  = mem_address_q;
        wdata_d        = wdata_q;
        rsp_valid_d    = 1'b0;
        rsp_rdata_d    = rsp_rdata_q;
        wait_cnt_d     = wait_cnt_q;
`ifdef MEM_BURST_READ_EN
        beats_left_d   = beats_left_q;
        rsp_last_d     = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    mem_address_d  = bus.req_addr;
                    wdata_d        = bus.req_wdata;
                    mem_write_en_d = bus.req_we;
`ifdef MEM_BURST_READ_EN
                    beats_left_d   = bus.req_we ? 3'd0 : bus.req_len;
`endif
                end
            end
            WRITE: begin
                rsp_valid_d = 1'b1;
`ifdef MEM_BURST_READ_EN
                rsp_last_d  = 1'b1;
`endif
            end
            RADDR: begin
                wait_cnt_d = WAIT_LOAD;
            end
            RWAIT: begin
                if (wait_cnt_q != 2'd0) begin
                    wait_cnt_d = wait_cnt_q - 2'd1;
                end
            end
            RCAP: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = mem_data;
                if (more_beats) begin
                    mem_address_d = mem_address_q + ADDR_ONE;
                end
`ifdef MEM_BURST_READ_EN
                rsp_last_d = !more_beats;
                if (more_beats) begin
                    beats_left_d = beats_left_q - 3'd1;
                end
`endif
            end
            default: begin
                mem_write_en_d = 1'b0;
            end
        endcase
    end

    // Outputs come straight from flops; the bus is driven only while the
    // registered write enable is high, the memory drives it otherwise.
    assign bus.req_ready = req_ready;
    assign bus.busy      = (state_q != IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
`ifdef MEM_BURST_READ_EN
    assign bus.rsp_last  = rsp_last_q;
`endif
    assign mem_write_en  = mem_write_en_q;
    assign mem_address   = mem_address_q;
    assign mem_data      = mem_write_en_q ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed testbench for mem_bus_master. Two instances share clk/rst:
// dut0 with READ_WAIT=0 and dut1 with READ_WAIT=2, each with its own
// 32x8 single-port memory model (registered output, one-edge latency).
module tb_mem_bus_master;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    mem_bus_master_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) bus0 ();
    mem_bus_master_if #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) bus1 ();

    logic       we0, we1;
    logic [4:0] addr0, addr1;
    wire  [7:0] mem_data0, mem_data1;
    logic [7:0] mem0 [32];
    logic [7:0] mem1 [32];
    logic [7:0] mem0_out, mem1_out;

    mem_bus_master #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .READ_WAIT(0)) dut0 (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus0.slave),
        .mem_write_en (we0),
        .mem_address  (addr0),
        .mem_data     (mem_data0)
    );

    mem_bus_master #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .READ_WAIT(2)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus1.slave),
        .mem_write_en (we1),
        .mem_address  (addr1),
        .mem_data     (mem_data1)
    );

    // Memory models: write on the edge while write_en is high, otherwise
    // load the output register; the memory drives the bus iff write_en=0.
    always @(posedge clk) begin
        if (we0) mem0[addr0] <= mem_data0;
        else     mem0_out    <= mem0[addr0];
    end

    always @(posedge clk) begin
        if (we1) mem1[addr1] <= mem_data1;
        else     mem1_out    <= mem1[addr1];
    end

    assign mem_data0 = we0 ? 8'bz : mem0_out;
    assign mem_data1 = we1 ? 8'bz : mem1_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic w, input logic [4:0] a, input logic [7:0] d);
        bus0.req_valid = v;
        bus0.req_we    = w;
        bus0.req_addr  = a;
        bus0.req_wdata = d;
    endtask

    task automatic applyStimulusWait(input logic v, input logic w, input logic [4:0] a, input logic [7:0] d);
        bus1.req_valid = v;
        bus1.req_we    = w;
        bus1.req_addr  = a;
        bus1.req_wdata = d;
    endtask

    // Single store on dut0 launched from an idle cycle; response in cycle 2.
    task automatic doStore0(input logic [4:0] a, input logic [7:0] d);
        applyStimulus(1'b1, 1'b1, a, d);
        step();
        applyStimulus(1'b0, 1'b0, a, d);
        step();
        checkOutput("store_rsp", 32'(bus0.rsp_valid), 32'd1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        applyStimulus(1'b0, 1'b0, 5'd0, 8'd0);
        applyStimulusWait(1'b0, 1'b0, 5'd0, 8'd0);
`ifdef MEM_BURST_READ_EN
        bus0.req_len = 3'd0;
        bus1.req_len = 3'd0;
`endif

        // Reset state
        #2;
        checkOutput("rst_ready",  32'(bus0.req_ready), 32'd0);
        checkOutput("rst_busy",   32'(bus0.busy),      32'd0);
        checkOutput("rst_we",     32'(we0),            32'd0);
        checkOutput("rst_addr",   32'(addr0),          32'd0);
        checkOutput("rst_rsp",    32'(bus0.rsp_valid), 32'd0);
        checkOutput("rst_rdata",  32'(bus0.rsp_rdata), 32'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        checkOutput("idle_ready0", 32'(bus0.req_ready), 32'd1);
        checkOutput("idle_ready1", 32'(bus1.req_ready), 32'd1);
        checkOutput("idle_bus",    32'(mem_data0),      32'(mem0_out));

        // Store addr 5 <- A5
        applyStimulus(1'b1, 1'b1, 5'd5, 8'hA5);
        step();
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        checkOutput("st_c1_busy",  32'(bus0.busy),      32'd1);
        checkOutput("st_c1_we",    32'(we0),            32'd1);
        checkOutput("st_c1_addr",  32'(addr0),          32'd5);
        checkOutput("st_c1_bus",   32'(mem_data0),      32'hA5);
        checkOutput("st_c1_rsp",   32'(bus0.rsp_valid), 32'd0);
        checkOutput("st_c1_ready", 32'(bus0.req_ready), 32'd0);
        step();
        checkOutput("st_c2_rsp",   32'(bus0.rsp_valid), 32'd1);
        checkOutput("st_c2_we",    32'(we0),            32'd0);
        checkOutput("st_c2_busy",  32'(bus0.busy),      32'd0);

        // Load addr 5 -> A5 in cycle 3
        applyStimulus(1'b1, 1'b0, 5'd5, 8'h00);
        step();
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        checkOutput("ld_c1_busy", 32'(bus0.busy),      32'd1);
        checkOutput("ld_c1_we",   32'(we0),            32'd0);
        checkOutput("ld_c1_rsp",  32'(bus0.rsp_valid), 32'd0);
        step();
        checkOutput("ld_c2_rsp",  32'(bus0.rsp_valid), 32'd0);
        checkOutput("ld_c2_bus",  32'(mem_data0),      32'hA5);
        step();
        checkOutput("ld_c3_rsp",   32'(bus0.rsp_valid), 32'd1);
        checkOutput("ld_c3_rdata", 32'(bus0.rsp_rdata), 32'hA5);

        // Back-to-back: store 1F <- 3C, then load 1F with req_valid held
        applyStimulus(1'b1, 1'b1, 5'h1F, 8'h3C);
        step();
        checkOutput("b2b_ld_rsp_clear", 32'(bus0.rsp_valid), 32'd0);
        checkOutput("b2b_rdata_hold",   32'(bus0.rsp_rdata), 32'hA5);
        applyStimulus(1'b1, 1'b0, 5'h1F, 8'h00);
        step();
        checkOutput("b2b_st_rsp",   32'(bus0.rsp_valid), 32'd1);
        checkOutput("b2b_st_ready", 32'(bus0.req_ready), 32'd1);
        step();
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        checkOutput("b2b_ld_busy", 32'(bus0.busy), 32'd1);
        checkOutput("b2b_ld_addr", 32'(addr0),     32'h1F);
        checkOutput("b2b_ld_we",   32'(we0),       32'd0);
        step();
        step();
        checkOutput("b2b_ld_rsp",   32'(bus0.rsp_valid), 32'd1);
        checkOutput("b2b_ld_rdata", 32'(bus0.rsp_rdata), 32'h3C);
        step();
        checkOutput("addr_hold_idle", 32'(addr0), 32'h1F);

        // READ_WAIT=2 instance: store addr 0 <- 11, then load it back
        applyStimulusWait(1'b1, 1'b1, 5'd0, 8'h11);
        step();
        applyStimulusWait(1'b0, 1'b0, 5'd0, 8'h00);
        step();
        checkOutput("rw_st_rsp", 32'(bus1.rsp_valid), 32'd1);
        applyStimulusWait(1'b1, 1'b0, 5'd0, 8'h00);
        step();
        applyStimulusWait(1'b0, 1'b0, 5'd0, 8'h00);
        checkOutput("rw_c1_busy", 32'(bus1.busy), 32'd1);
        step();
        checkOutput("rw_c2_busy", 32'(bus1.busy), 32'd1);
        step();
        checkOutput("rw_c3_busy", 32'(bus1.busy),      32'd1);
        checkOutput("rw_c3_rsp",  32'(bus1.rsp_valid), 32'd0);
        step();
        checkOutput("rw_c4_busy", 32'(bus1.busy),      32'd1);
        checkOutput("rw_c4_rsp",  32'(bus1.rsp_valid), 32'd0);
        step();
        checkOutput("rw_c5_rsp",   32'(bus1.rsp_valid), 32'd1);
        checkOutput("rw_c5_rdata", 32'(bus1.rsp_rdata), 32'h11);
        checkOutput("rw_c5_busy",  32'(bus1.busy),      32'd0);

        // Reset during WRITE: preload addr 7 <- 42, then abort store of FF
        doStore0(5'd7, 8'h42);
        applyStimulus(1'b1, 1'b1, 5'd7, 8'hFF);
        step();
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        checkOutput("rstw_we_before", 32'(we0), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstw_we_async", 32'(we0),            32'd0);
        checkOutput("rstw_busy",     32'(bus0.busy),      32'd0);
        checkOutput("rstw_rdata",    32'(bus0.rsp_rdata), 32'd0);
        #1;
        rst = 1'b0;
        step();
        checkOutput("rstw_no_rsp", 32'(bus0.rsp_valid), 32'd0);
        checkOutput("rstw_ready",  32'(bus0.req_ready), 32'd1);
        applyStimulus(1'b1, 1'b0, 5'd7, 8'h00);
        step();
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        step();
        step();
        checkOutput("rstw_ld_rsp",   32'(bus0.rsp_valid), 32'd1);
        checkOutput("rstw_ld_rdata", 32'(bus0.rsp_rdata), 32'h42);

`ifdef MEM_BURST_READ_EN
        // Burst load from 30 with len 3 wraps to addresses 31, 0, 1
        doStore0(5'd30, 8'hA0);
        checkOutput("bst_store_last", 32'(bus0.rsp_last), 32'd1);
        doStore0(5'd31, 8'hA1);
        doStore0(5'd0,  8'hB0);
        doStore0(5'd1,  8'hB1);
        bus0.req_len = 3'd3;
        applyStimulus(1'b1, 1'b0, 5'd30, 8'h00);
        step();
        applyStimulus(1'b0, 1'b0, 5'd0, 8'h00);
        bus0.req_len = 3'd0;
        step();
        checkOutput("bst_ready_mid", 32'(bus0.req_ready), 32'd0);
        step();
        checkOutput("bst_b0_rsp",   32'(bus0.rsp_valid), 32'd1);
        checkOutput("bst_b0_rdata", 32'(bus0.rsp_rdata), 32'hA0);
        checkOutput("bst_b0_last",  32'(bus0.rsp_last),  32'd0);
        checkOutput("bst_b0_ready", 32'(bus0.req_ready), 32'd0);
        step();
        step();
        checkOutput("bst_b1_rdata", 32'(bus0.rsp_rdata), 32'hA1);
        checkOutput("bst_b1_last",  32'(bus0.rsp_last),  32'd0);
        step();
        step();
        checkOutput("bst_b2_rdata", 32'(bus0.rsp_rdata), 32'hB0);
        checkOutput("bst_b2_busy",  32'(bus0.busy),      32'd1);
        step();
        step();
        checkOutput("bst_b3_rsp",   32'(bus0.rsp_valid), 32'd1);
        checkOutput("bst_b3_rdata", 32'(bus0.rsp_rdata), 32'hB1);
        checkOutput("bst_b3_last",  32'(bus0.rsp_last),  32'd1);
        checkOutput("bst_b3_ready", 32'(bus0.req_ready), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
